// File: rtl/space_wire_time_code_hub.sv
// space_wire_time_code_hub: multi-port SpaceWire time-code capture, arbitration and
// master/slave system-time keeping with rebroadcast to the link transmitters.
module space_wire_time_code_hub #(
  parameter int N_PORTS     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [N_PORTS-1:0]     i_rx_clk,
  input  logic [N_PORTS-1:0]     i_got_time_code,
  input  logic [8*N_PORTS-1:0]   i_rx_time_code,
  input  logic                   i_master_mode,
  input  logic                   i_tick_in,
  input  logic [1:0]             i_control_flags_in,
  output logic [5:0]             o_time_out,
  output logic [1:0]             o_control_flags_out,
  output logic                   o_tick_out,
  output logic [7:0]             o_tx_time_code,
  output logic [N_PORTS-1:0]     o_tx_tick,
  output logic                   o_seq_error,
  output logic                   o_collision
);
  logic [N_PORTS-1:0] evt;
  logic [7:0]         hold [N_PORTS];
  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    logic [7:0]             hold_q;
    logic                   tgl_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   evt_q;
    always_ff @(posedge i_rx_clk[g] or negedge i_reset_n)
      if (!i_reset_n) begin
        hold_q <= '0;
        tgl_q  <= 1'b0;
      end else if (i_got_time_code[g]) begin
        hold_q <= i_rx_time_code[8*g +: 8];
        tgl_q  <= ~tgl_q;
      end
    // hold_q is stable for the whole synchroniser delay, so evt may read it directly
    always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
        sync_q <= '0;
        last_q <= 1'b0;
        evt_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_q};
        last_q <= sync_q[SYNC_STAGES-1];
        evt_q  <= sync_q[SYNC_STAGES-1] ^ last_q;
      end
    assign hold[g] = hold_q;
    assign evt[g]  = evt_q;
  end
  logic [5:0]         time_q, time_d, inc;
  logic [1:0]         flags_q, flags_d;
  logic               tick_q, tick_d, seq_q, seq_d, coll_q, coll_d;
  logic [7:0]         tx_code_q, tx_code_d, code;
  logic [N_PORTS-1:0] tx_tick_q, tx_tick_d, win;
  always_comb begin
    code = '0;
    win  = '0;
    for (int p = N_PORTS - 1; p >= 0; p--) begin
      code = evt[p] ? hold[p] : code;
      win  = evt[p] ? N_PORTS'(1) << p : win;
    end
    inc       = time_q + 6'd1;
    time_d    = time_q;
    flags_d   = flags_q;
    tick_d    = 1'b0;
    tx_tick_d = '0;
    tx_code_d = tx_code_q;
    seq_d     = 1'b0;
    coll_d    = |(evt & (evt - N_PORTS'(1)));
    if (i_master_mode) begin
      if (i_tick_in) begin
        time_d    = inc;
        flags_d   = i_control_flags_in;
        tick_d    = 1'b1;
        tx_tick_d = '1;
        tx_code_d = {i_control_flags_in, inc};
      end
    end else if (|evt) begin
      if (code[5:0] == inc) begin
        time_d    = inc;
        flags_d   = code[7:6];
        tick_d    = 1'b1;
        tx_tick_d = ~win;
        tx_code_d = code;
      end else if (code[5:0] != time_q) begin
        time_d  = code[5:0];
        flags_d = code[7:6];
        seq_d   = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      time_q    <= '0;
      flags_q   <= '0;
      tick_q    <= 1'b0;
      tx_tick_q <= '0;
      tx_code_q <= '0;
      seq_q     <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      time_q    <= time_d;
      flags_q   <= flags_d;
      tick_q    <= tick_d;
      tx_tick_q <= tx_tick_d;
      tx_code_q <= tx_code_d;
      seq_q     <= seq_d;
      coll_q    <= coll_d;
    end
  assign o_time_out          = time_q;
  assign o_control_flags_out = flags_q;
  assign o_tick_out          = tick_q;
  assign o_tx_tick           = tx_tick_q;
  assign o_tx_time_code      = tx_code_q;
  assign o_seq_error         = seq_q;
  assign o_collision         = coll_q;
endmodule
